// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// RV32M execution unit that sits beside the ALU in the EX stage.
// - MUL, MULH, MULHSU and MULHU finish in a fixed two-cycle latency.
// - DIV, DIVU, REM and REMU use radix-2 restoring division. Each cycle
//   produces one quotient bit.
// - Divide-by-zero and signed overflow are resolved in IDLE with no
//   iteration.
// - A start/busy/done handshake lets the hazard unit stall the pipeline.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request a new operation (sampled only in IDLE)
//   funct3  in   M-op select (000 MUL .. 111 REMU)
//   op_a    in   rs1 value (multiplicand / dividend)
//   op_b    in   rs2 value (multiplier / divisor)
//   flush   in   abort any in-flight operation without a done pulse
//   busy    out  high while in MUL or DIV
//   done    out  one-cycle pulse, result valid
//   result  out  last completed result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  // funct3[2] is implied by the MUL/DIV state, so only the low bits are kept.
  logic [1:0]      fn_q;
  // In MUL: the raw operands. In DIV: a_q is the dividend that shifts into
  // the quotient, and b_q is the divisor magnitude.
  logic [XLEN-1:0] a_q, b_q, rem_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_quo_q, neg_rem_q;

  // ---------------- IDLE: division setup and special cases ----------------
  logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    div_signed  = ~funct3[0];                 // DIV / REM
    a_neg       = div_signed & op_a[XLEN-1];
    b_neg       = div_signed & op_b[XLEN-1];
    a_mag       = a_neg ? -op_a : op_a;       // 0x80000000 stays itself as unsigned
    b_mag       = b_neg ? -op_b : op_b;
    div_zero    = (op_b == '0);
    div_ovf     = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_res = '1;
    if (div_zero)     special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0   : op_a;
  end

  // ---------------- MUL: product from latched operands ----------------
  // Sign-extending both operands to 2*XLEN gives the correct low 2*XLEN
  // product bits for every signed/unsigned mix.
  logic            mul_a_sx, mul_b_sx;
  logic [2*XLEN-1:0] mul_a_w, mul_b_w, mul_prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_a_sx = (fn_q != 2'b11);               // MULH, MULHSU (MUL low half is sign-agnostic)
    mul_b_sx = (fn_q == 2'b01);               // MULH only
    mul_a_w  = {{XLEN{mul_a_sx & a_q[XLEN-1]}}, a_q};
    mul_b_w  = {{XLEN{mul_b_sx & b_q[XLEN-1]}}, b_q};
    mul_prod = mul_a_w * mul_b_w;
    mul_res  = (fn_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // ---------------- DIV: one restoring step ----------------
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_fits;
  logic [XLEN-1:0] step_rem_d, step_quo_d, div_res;

  always_comb begin
    div_shift  = {rem_q, a_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, b_q};
    div_fits   = ~div_diff[XLEN];             // no borrow: divisor fits
    step_rem_d = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    step_quo_d = {a_q[XLEN-2:0], div_fits};
    if (fn_q[1]) div_res = neg_rem_q ? -step_rem_d : step_rem_d;
    else         div_res = neg_quo_q ? -step_quo_d : step_quo_d;
  end

  // ---------------- Control FSM with registered outputs ----------------
  // NOTE: all state is updated with non-blocking assignments, so every branch
  // reads the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so that result reads 0
      // after reset and nothing starts out unknown.
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      fn_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fn_q <= funct3[1:0];
            if (!funct3[2]) begin
              a_q     <= op_a;
              b_q     <= op_b;
              busy_q  <= 1'b1;
              state_q <= S_MUL;
            end else if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              a_q       <= a_mag;
              b_q       <= b_mag;
              rem_q     <= '0;
              cnt_q     <= CW'(XLEN-1);
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              busy_q    <= 1'b1;
              state_q   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          result_q <= mul_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DIV: begin
          a_q   <= step_quo_d;
          rem_q <= step_rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= div_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed-vector bench for muldiv_unit. The expected values were worked out
// by hand. The cycle that presents start is called N. Latency is the number of
// cycles from N until done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it until done. Outputs are sampled on negedges.
  // With hold set, start stays high and the operands change while the op runs.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int   cyc;
    bit   seen, busy_bad;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    cyc = 1; seen = 0; busy_bad = 0;
    if (hold) begin op_a = 32'd9; op_b = 32'd2; end
    else start = 1'b0;
    while (cyc <= 60) begin
      if (done) begin
        if (busy) busy_bad = 1;
        seen = 1;
        break;
      end
      if (busy !== (cyc < lat)) busy_bad = 1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    rst = 1'b0;

    // Multiply
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 2, 0);

    // Divide
    run_op("div",  3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 0);
    run_op("rem",  3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 0);
    run_op("divu", 3'b101, 32'd100,       32'd7, 32'd14,        33, 0);
    run_op("remu", 3'b111, 32'd100,       32'd7, 32'd2,         33, 0);

    // Special cases
    run_op("divu0",   3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem0",    3'b110, 32'd5,        32'd0,         32'd5,         1, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

    // Flush at N+10 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'hFFFF_FFEC; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);                 // N+1
    start = 1'b0;
    repeat (9) @(negedge clk);      // N+10
    flush = 1'b1;
    @(negedge clk);                 // N+11
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_res", result, last_res);
    run_op("mul_after_flush", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);

    // flush wins over start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flushstart_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("flushstart_done", 32'(done), 32'd0);
    check("flushstart_res", result, last_res);

    // start held high with other operands during a DIVU
    run_op("hold_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1);

    // Synchronous reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res", result, 32'd0);
    rst = 1'b0;
    last_res = '0;

    // Unit is usable after reset
    run_op("div_after_rst", 3'b100, 32'd1000, 32'hFFFF_FFF7, 32'hFFFF_FF91, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
